// File: rtl/exec_controller_if.sv
// Datapath-facing bundle of the execution sequencer: PC/instruction/RUWr in,
// commit strobe, gated write enable and display status out.
interface exec_controller_if;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ruwr_in;
    logic        pc_en;
    logic        ruwr_out;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] instr_count;

    modport master (
        output pc, inst, ruwr_in,
        input  pc_en, ruwr_out, halted, state, instr_count
    );

    modport slave (
        input  pc, inst, ruwr_in,
        output pc_en, ruwr_out, halted, state, instr_count
    );
endinterface

// File: rtl/exec_controller.sv
// Execution sequencer for the single-cycle RV32 datapath: decides which cycles
// commit an instruction (free-run at a divided rate, debounced single-step, halt).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   STOP  | idle, waiting for run switch or a step press
//   STEP  | one-cycle single-step decision (commit or halt)
//   RUN   | commit on every divider tick until switch drops or halt hit
//   HALT  | stopped on EBREAK/breakpoint; a step press commits past it
module exec_controller #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] RUN_DIV         = 32'd25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_step,
    input  logic              sw_run,
    input  logic              bp_en,
    input  logic [31:0]       bp_addr,
    exec_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic        stable_q, stable_prev_q;
    logic [15:0] db_cnt_q;
    logic [31:0] div_cnt_q;
    logic        pc_en_q;
    logic [31:0] count_q;

    logic        step_req;
    logic        halt_cond;
    logic        tick;
    logic        commit;

    // Button: two-flop synchronizer, then level debounce on the synced value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            db_cnt_q      <= '0;
        end else begin
            sync1_q       <= btn_step;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            if (sync2_q == stable_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                stable_q <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 16'd1;
            end
        end
    end

    assign step_req  = stable_q & ~stable_prev_q;
    assign halt_cond = (bus.inst == EBREAK) | (bp_en & (bus.pc == bp_addr));
    assign tick      = (state_q == ST_RUN) && (div_cnt_q == RUN_DIV - 32'd1);

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_STOP: begin
                if (sw_run)        state_d = ST_RUN;
                else if (step_req) state_d = ST_STEP;
            end
            ST_STEP: begin
                if (halt_cond) begin
                    state_d = ST_HALT;
                end else begin
                    commit  = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_RUN: begin
                // Dropping the switch wins over a coincident tick.
                if (!sw_run) begin
                    state_d = ST_STOP;
                end else if (tick) begin
                    if (halt_cond) state_d = ST_HALT;
                    else           commit  = 1'b1;
                end
            end
            ST_HALT: begin
                if (step_req) begin
                    commit  = 1'b1;
                    state_d = ST_STOP;
                end else if (!sw_run) begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Divider reads 0 in every cycle the FSM is not in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else if (state_q == ST_RUN && state_d == ST_RUN && !tick) begin
            div_cnt_q <= div_cnt_q + 32'd1;
        end else begin
            div_cnt_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
            pc_en_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_en_q <= commit;
            if (pc_en_q) count_q <= count_q + 32'd1;
        end
    end

    assign bus.pc_en       = pc_en_q;
    assign bus.ruwr_out    = bus.ruwr_in & pc_en_q;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;
endmodule
